// File: rtl/i2c_bus_mon_if.sv
// Pad-side and status signals of the I2C line monitor.
// The master side drives enable and raw pads; the slave side is the monitor itself.
interface i2c_bus_mon_if;
    logic       en;
    logic       scl_in;
    logic       sda_in;
    logic [7:0] i2ctrans;
    logic       bus_busy;

    modport master (
        output en,
        output scl_in,
        output sda_in,
        input  i2ctrans,
        input  bus_busy
    );

    modport slave (
        input  en,
        input  scl_in,
        input  sda_in,
        output i2ctrans,
        output bus_busy
    );
endinterface

// File: rtl/i2c_bus_mon.sv
// I2C line monitor: synchronises and glitch-filters SCL/SDA, derives edge and
// START/STOP pulses, and tracks bus-busy including the idle-bus timeout.
module i2c_bus_mon #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int BUSFREE_CYC = 64
) (
    input  logic          clk,
    input  logic          rst,
    i2c_bus_mon_if.slave  bus
);

    localparam int CNT_W  = $clog2(FILT_LEN + 1);
    localparam int FREE_W = (BUSFREE_CYC > 1) ? $clog2(BUSFREE_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FILT_LEN - 1);
    localparam logic [FREE_W-1:0] FREE_LAST = FREE_W'(BUSFREE_CYC - 1);

    typedef enum logic {
        ST_FREE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Index 0 is SCL, index 1 is SDA throughout.
    logic [1:0] raw_line;
    logic [1:0] s_line;
    logic [1:0] f_line;
    logic [1:0] fd_line;
    logic [1:0] rise_line;
    logic [1:0] fall_line;

    logic start_pulse;
    logic stop_pulse;
    logic busy;

    state_t            state_reg;
    state_t            state_next;
    logic [FREE_W-1:0] free_reg;
    logic [FREE_W-1:0] free_next;

    assign raw_line = {bus.sda_in, bus.scl_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic [CNT_W-1:0]       cnt_next;
            logic                   f_reg;
            logic                   f_next;
            logic                   fd_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg <= '1;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_line[gi]};
                end
            end

            assign s_line[gi] = sync_reg[SYNC_STAGES-1];

            // Level only follows the synchronised line after FILT_LEN
            // consecutive disagreeing samples; any agreement restarts the count.
            always_comb begin
                f_next   = f_reg;
                cnt_next = '0;
                if (!bus.en) begin
                    f_next = 1'b1;
                end else if (s_line[gi] == f_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    f_next = s_line[gi];
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    f_reg   <= 1'b1;
                    cnt_reg <= '0;
                    fd_reg  <= 1'b1;
                end else begin
                    f_reg   <= f_next;
                    cnt_reg <= cnt_next;
                    fd_reg  <= bus.en ? f_reg : 1'b1;
                end
            end

            assign f_line[gi]    = f_reg;
            assign fd_line[gi]   = fd_reg;
            assign rise_line[gi] = f_reg & ~fd_reg;
            assign fall_line[gi] = ~f_reg & fd_reg;
        end
    endgenerate

    // SCL must be high both before and after the SDA edge; a simultaneous
    // SCL flip leaves one of f/fd low and suppresses the condition.
    assign start_pulse = fall_line[1] & f_line[0] & fd_line[0];
    assign stop_pulse  = rise_line[1] & f_line[0] & fd_line[0];

    always_comb begin
        state_next = state_reg;
        free_next  = '0;
        if (!bus.en) begin
            state_next = ST_FREE;
        end else begin
            case (state_reg)
                ST_FREE: begin
                    if (start_pulse) begin
                        state_next = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (start_pulse) begin
                        state_next = ST_BUSY;
                    end else if (stop_pulse) begin
                        state_next = ST_FREE;
                    end else if (free_reg == FREE_LAST) begin
                        state_next = ST_FREE;
                    end else if (f_line[0] & f_line[1]) begin
                        free_next = free_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_FREE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FREE;
            free_reg  <= '0;
        end else begin
            state_reg <= state_next;
            free_reg  <= free_next;
        end
    end

    assign busy = (state_reg == ST_BUSY);

    assign bus.i2ctrans = {busy, s_line[0], stop_pulse, start_pulse,
                           fall_line[0], rise_line[0], f_line[1], f_line[0]};
    assign bus.bus_busy = busy;

endmodule

// File: tb/tb_i2c_bus_mon.sv
// Scoreboard bench for i2c_bus_mon: expected pulse events are queued as pad
// stimulus is applied and matched against pulses seen on i2ctrans.
module tb_i2c_bus_mon;

    localparam int LAT = 5;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    always #5 clk = ~clk;

    i2c_bus_mon_if bus ();

    i2c_bus_mon #(
        .SYNC_STAGES(2),
        .FILT_LEN(3),
        .BUSFREE_CYC(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int b = 2; b <= 5; b++) begin
            if (bus.i2ctrans[b] === 1'b1) obs_q.push_back('{b, cyc});
        end
    end

    function automatic string kname(int k);
        case (k)
            2: return "rise";
            3: return "fall";
            4: return "start";
            5: return "stop";
            default: return "unknown";
        endcase
    endfunction

    task automatic go_to(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_at(int c);
        go_to(c);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        n = cyc;
        @(negedge clk);
        total++;
        if (bus.i2ctrans !== 8'h43) $display("FAIL reset_trans: got %h expected 43", bus.i2ctrans);
        else begin passed++; $display("reset: i2ctrans=%h", bus.i2ctrans); end
        total++;
        if (bus.bus_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.bus_busy);
        else passed++;
        obs_q.delete();
        sample_at(n + 10);
        total++;
        if (obs_q.size() != 0) $display("FAIL idle_pulses: got %0d events expected 0", obs_q.size());
        else begin passed++; $display("idle: no pulses over 10 cycles"); end
        total++;
        if (bus.i2ctrans !== 8'h43) $display("FAIL idle_trans: got %h expected 43", bus.i2ctrans);
        else passed++;
    endtask

    task automatic test_start_fall();
        int n;
        ev_t e, o;
        n = cyc;
        obs_q.delete();
        bus.sda_in = 1'b0;
        exp_q.push_back('{4, n + LAT});
        sample_at(n + 5);
        total++;
        if (bus.bus_busy !== 1'b0) $display("FAIL start_busy_early: got %b expected 0", bus.bus_busy);
        else passed++;
        sample_at(n + 6);
        total++;
        if (bus.bus_busy !== 1'b1 || bus.i2ctrans[7] !== 1'b1)
            $display("FAIL start_busy: got %b/%b expected 1/1", bus.bus_busy, bus.i2ctrans[7]);
        else passed++;
        go_to(n + 20);
        bus.scl_in = 1'b0;
        exp_q.push_back('{3, n + 20 + LAT});
        sample_at(n + 32);
        total++;
        if (bus.i2ctrans[1:0] !== 2'b00) $display("FAIL start_levels: got %b expected 00", bus.i2ctrans[1:0]);
        else passed++;
        total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL start_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL start_missing: got none expected %s at %0d", kname(e.kind), e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.kind != e.kind || o.cyc != e.cyc)
                    $display("FAIL start_event: got %s at %0d expected %s at %0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc);
                else begin passed++; $display("start_fall: %s at cycle %0d", kname(o.kind), o.cyc); end
            end
        end
    endtask

    task automatic test_stop();
        int n;
        ev_t e, o;
        n = cyc;
        obs_q.delete();
        bus.scl_in = 1'b1;
        exp_q.push_back('{2, n + LAT});
        go_to(n + 10);
        bus.sda_in = 1'b1;
        exp_q.push_back('{5, n + 10 + LAT});
        sample_at(n + 15);
        total++;
        if (bus.bus_busy !== 1'b1) $display("FAIL stop_busy_held: got %b expected 1", bus.bus_busy);
        else passed++;
        sample_at(n + 16);
        total++;
        if (bus.bus_busy !== 1'b0) $display("FAIL stop_busy_clear: got %b expected 0", bus.bus_busy);
        else passed++;
        sample_at(n + 22);
        total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL stop_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL stop_missing: got none expected %s at %0d", kname(e.kind), e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.kind != e.kind || o.cyc != e.cyc)
                    $display("FAIL stop_event: got %s at %0d expected %s at %0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc);
                else begin passed++; $display("stop: %s at cycle %0d", kname(o.kind), o.cyc); end
            end
        end
    endtask

    task automatic test_repeated_start();
        int n;
        ev_t e, o;
        n = cyc;
        obs_q.delete();
        bus.sda_in = 1'b0;
        exp_q.push_back('{4, n + LAT});
        sample_at(n + 6);
        total++;
        if (bus.bus_busy !== 1'b1) $display("FAIL rstart_busy_set: got %b expected 1", bus.bus_busy);
        else passed++;
        go_to(n + 10);
        bus.scl_in = 1'b0;
        exp_q.push_back('{3, n + 10 + LAT});
        go_to(n + 18);
        bus.sda_in = 1'b1;
        go_to(n + 26);
        bus.scl_in = 1'b1;
        exp_q.push_back('{2, n + 26 + LAT});
        go_to(n + 36);
        bus.sda_in = 1'b0;
        exp_q.push_back('{4, n + 36 + LAT});
        sample_at(n + 40);
        total++;
        if (bus.bus_busy !== 1'b1) $display("FAIL rstart_busy_before: got %b expected 1", bus.bus_busy);
        else passed++;
        sample_at(n + 42);
        total++;
        if (bus.bus_busy !== 1'b1) $display("FAIL rstart_busy_after: got %b expected 1", bus.bus_busy);
        else passed++;
        sample_at(n + 46);
        total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL rstart_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL rstart_missing: got none expected %s at %0d", kname(e.kind), e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.kind != e.kind || o.cyc != e.cyc)
                    $display("FAIL rstart_event: got %s at %0d expected %s at %0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc);
                else begin passed++; $display("repeated_start: %s at cycle %0d", kname(o.kind), o.cyc); end
            end
        end
    endtask

    task automatic test_glitch();
        int  n, h;
        bit  dropped;
        ev_t e, o;
        n = cyc;
        dropped = 1'b0;
        obs_q.delete();
        bus.scl_in = 1'b0;
        for (int c = n; c <= n + 10; c++) begin
            go_to(c);
            if (c == n + 2) bus.scl_in = 1'b1;
            @(negedge clk);
            if (bus.i2ctrans[0] !== 1'b1) dropped = 1'b1;
        end
        total++;
        if (dropped) $display("FAIL glitch2_level: got f_scl=0 during 2-cycle glitch expected 1");
        else begin passed++; $display("glitch2: filtered scl held high"); end
        h = n + 12;
        go_to(h);
        bus.scl_in = 1'b0;
        exp_q.push_back('{3, h + LAT});
        go_to(h + 3);
        bus.scl_in = 1'b1;
        exp_q.push_back('{2, h + 3 + LAT});
        sample_at(h + 14);
        total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL glitch_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL glitch_missing: got none expected %s at %0d", kname(e.kind), e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.kind != e.kind || o.cyc != e.cyc)
                    $display("FAIL glitch_event: got %s at %0d expected %s at %0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc);
                else begin passed++; $display("glitch3: %s at cycle %0d", kname(o.kind), o.cyc); end
            end
        end
    endtask

    task automatic test_bus_free();
        int  a;
        ev_t e, o;
        a = cyc;
        obs_q.delete();
        bus.scl_in = 1'b0;
        exp_q.push_back('{3, a + LAT});
        go_to(a + 8);
        bus.sda_in = 1'b1;
        go_to(a + 16);
        bus.scl_in = 1'b1;
        exp_q.push_back('{2, a + 16 + LAT});
        // Both filtered lines are high from a+21; the 64th such cycle is a+84.
        sample_at(a + 84);
        total++;
        if (bus.bus_busy !== 1'b1) $display("FAIL free_busy_held: got %b expected 1", bus.bus_busy);
        else passed++;
        sample_at(a + 85);
        total++;
        if (bus.bus_busy !== 1'b0 || bus.i2ctrans[7] !== 1'b0)
            $display("FAIL free_busy_clear: got %b/%b expected 0/0", bus.bus_busy, bus.i2ctrans[7]);
        else begin passed++; $display("bus_free: busy cleared at cycle %0d", cyc); end
        sample_at(a + 90);
        total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL free_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL free_missing: got none expected %s at %0d", kname(e.kind), e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.kind != e.kind || o.cyc != e.cyc)
                    $display("FAIL free_event: got %s at %0d expected %s at %0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc);
                else begin passed++; $display("bus_free: %s at cycle %0d", kname(o.kind), o.cyc); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int  b;
        ev_t e, o;
        b = cyc;
        obs_q.delete();
        bus.sda_in = 1'b0;
        exp_q.push_back('{4, b + LAT});
        sample_at(b + 6);
        total++;
        if (bus.bus_busy !== 1'b1) $display("FAIL rmid_busy_set: got %b expected 1", bus.bus_busy);
        else passed++;
        go_to(b + 10);
        bus.scl_in = 1'b0;
        exp_q.push_back('{3, b + 10 + LAT});
        go_to(b + 20);
        rst = 1'b1;
        go_to(b + 21);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.i2ctrans !== 8'h43 || bus.bus_busy !== 1'b0)
            $display("FAIL rmid_trans: got %h/%b expected 43/0", bus.i2ctrans, bus.bus_busy);
        else begin passed++; $display("reset_mid: i2ctrans=%h", bus.i2ctrans); end
        sample_at(b + 23);
        total++;
        if (bus.i2ctrans !== 8'h03) $display("FAIL rmid_raw: got %h expected 03", bus.i2ctrans);
        else passed++;
        // Synchronisers reload from the low pads after reset, so the filter sees a fresh fall.
        exp_q.push_back('{3, b + 26});
        sample_at(b + 32);
        total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL rmid_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL rmid_missing: got none expected %s at %0d", kname(e.kind), e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.kind != e.kind || o.cyc != e.cyc)
                    $display("FAIL rmid_event: got %s at %0d expected %s at %0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc);
                else begin passed++; $display("reset_mid: %s at cycle %0d", kname(o.kind), o.cyc); end
            end
        end
    endtask

    task automatic test_en_off();
        int  c;
        ev_t e, o;
        c = cyc;
        obs_q.delete();
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        exp_q.push_back('{2, c + LAT});
        go_to(c + 10);
        bus.sda_in = 1'b0;
        exp_q.push_back('{4, c + 10 + LAT});
        sample_at(c + 16);
        total++;
        if (bus.bus_busy !== 1'b1) $display("FAIL en_busy_set: got %b expected 1", bus.bus_busy);
        else passed++;
        go_to(c + 20);
        bus.en = 1'b0;
        bus.scl_in = 1'b0;
        sample_at(c + 21);
        total++;
        if (bus.i2ctrans !== 8'h43 || bus.bus_busy !== 1'b0)
            $display("FAIL en_off_trans: got %h/%b expected 43/0", bus.i2ctrans, bus.bus_busy);
        else begin passed++; $display("en_off: i2ctrans=%h", bus.i2ctrans); end
        sample_at(c + 24);
        total++;
        if (bus.i2ctrans !== 8'h03) $display("FAIL en_off_raw: got %h expected 03", bus.i2ctrans);
        else passed++;
        go_to(c + 30);
        bus.en = 1'b1;
        exp_q.push_back('{3, c + 33});
        sample_at(c + 40);
        total++;
        if (bus.bus_busy !== 1'b0) $display("FAIL en_on_busy: got %b expected 0", bus.bus_busy);
        else passed++;
        total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL en_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL en_missing: got none expected %s at %0d", kname(e.kind), e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.kind != e.kind || o.cyc != e.cyc)
                    $display("FAIL en_event: got %s at %0d expected %s at %0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc);
                else begin passed++; $display("en_resume: %s at cycle %0d", kname(o.kind), o.cyc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_fall();
        test_stop();
        test_repeated_start();
        test_glitch();
        test_bus_free();
        test_reset_mid();
        test_en_off();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_bus_mon.md
Name: i2c_bus_mon

Overview:
- Front-end line monitor for the I2C block.
- Synchronises the raw SCL/SDA pad inputs to clk, glitch-filters them and produces one-cycle edge pulses.
- Detects START/STOP conditions and tracks bus-busy.
- Drives the i2ctrans transition vector consumed by the tx/rx bit engines and the master/slave controllers.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per line (minimum 2).
- FILT_LEN, 3, consecutive cycles a synchronised line must differ from its filtered value before the filtered value flips (minimum 1).
- BUSFREE_CYC, 64, consecutive cycles with filtered SCL=SDA=1 after which busy clears without a STOP.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  monitor enable; low forces idle outputs.
- scl_in  input  1  raw SCL pad input, asynchronous.
- sda_in  input  1  raw SDA pad input, asynchronous.
- i2ctrans  output  8  transition vector:
  - bit0 filtered SCL
  - bit1 filtered SDA
  - bit2 SCL rise pulse
  - bit3 SCL fall pulse
  - bit4 START pulse
  - bit5 STOP pulse
  - bit6 raw (synchronised, unfiltered) SCL
  - bit7 bus busy
- bus_busy  output  1  copy of i2ctrans[7], for the status register.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all synchroniser flops, filtered levels and their delayed copies load 1;
  - filter counters, free counter and busy load 0;
  - i2ctrans therefore reads 8'b0100_0011 and bus_busy=0 in the cycle after reset.
  - Reset mid-transfer aborts everything; no pulse is emitted on the reset cycle or the cycle after it.
- Synchroniser:
  - each line passes through SYNC_STAGES flops;
  - the last stage is s_scl/s_sda;
  - i2ctrans[6] = s_scl.
- Filter, per line:
  - registered level f and a counter cnt of width clog2(FILT_LEN+1).
  - If s == f: cnt <= 0.
  - Else if cnt == FILT_LEN-1: f <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A pulse shorter than FILT_LEN cycles never reaches f.
  - Latency from pad change to f change is SYNC_STAGES+FILT_LEN cycles (5 at defaults).
- Edge detect:
  - fd is f delayed by one cycle.
  - rise = f & ~fd; fall = ~f & fd.
  - Each pulse is high exactly one cycle, the first cycle f shows the new value.
  - i2ctrans[0]=f_scl, [1]=f_sda, [2]=scl rise, [3]=scl fall.
- START = sda fall & f_scl & fd_scl (SCL stable high across the SDA edge).
- STOP = sda rise & f_scl & fd_scl.
- SCL and SDA flipping in the same cycle: no START/STOP; SCL edge pulses are still emitted.
- Busy:
  - set on START;
  - cleared on STOP, or when the free counter reaches BUSFREE_CYC-1.
  - Free counter increments while f_scl & f_sda and busy; it resets to 0 otherwise.
  - START and free-timeout in the same cycle: START wins, busy stays 1.
  - Repeated START while busy: busy stays 1, START pulse emitted.
- en=0:
  - synchronisers keep running;
  - filters are forced to f=1, cnt=0; fd=1; busy=0;
  - all pulses are 0; i2ctrans = {0, s_scl, 6'b000011}.
  - On en rising, the filters resume from 1, so a line held low produces a fall pulse FILT_LEN cycles later and no START unless SDA falls with SCL stable high.
- No combinational path from scl_in/sda_in to any output. Outputs are registers, or one-level logic of registers f/fd/busy.

Test Plan:
- Reset → i2ctrans=8'h43, bus_busy=0. Hold scl_in=sda_in=1 for 10 cycles → no pulses.
- sda_in 1→0 with scl_in=1, then scl_in 1→0 after 20 cycles:
  - START pulse exactly 5 cycles after the sda edge; bus_busy=1 the next cycle;
  - SCL fall pulse 5 cycles after the scl edge; STOP never asserted.
- Glitch of 2 cycles low on scl_in (FILT_LEN=3) → i2ctrans[0] stays 1, no fall pulse. A 3-cycle glitch → fall pulse, then rise pulse 3 cycles after the line returns high.
- Busy bus, scl=1, sda_in 0→1 → STOP pulse, bus_busy=0 one cycle later. Repeat START while busy → START pulse, busy stays 1.
- Set busy via START, then hold both lines high with no STOP for 64 cycles → bus_busy clears at the 64th cycle, no STOP pulse.
- Assert rst during a transfer with scl low; also set en=0 while busy → outputs return to 8'h43 or the en=0 pattern next cycle, busy=0, no spurious pulses.
